// File: rtl/reaction_timer.sv
`default_nettype none
// ============================================================================
// Module   : reaction_timer
// Brief    : Reaction-time meter for the starting-lights game. Arms on a new
//            light sequence, counts milliseconds in BCD from lights-out until
//            the player's key press, flags false starts and saturation, and
//            keeps the best valid time.
// Revision : 1.0 - initial release
// ============================================================================
module reaction_timer #(
   parameter int SAT_VALUE = 9999
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_ms,
   input  logic       arm,
   input  logic       lights_out,
   input  logic       key_n,
   output logic [3:0] bcd0,
   output logic [3:0] bcd1,
   output logic [3:0] bcd2,
   output logic [3:0] bcd3,
   output logic [3:0] best0,
   output logic [3:0] best1,
   output logic [3:0] best2,
   output logic [3:0] best3,
   output logic       valid,
   output logic       false_start,
   output logic       overflow,
   output logic       running
);

   // Saturation value laid out as four BCD digits, thousands digit on top.
   localparam logic [15:0] C_SAT_BCD = {4'((SAT_VALUE / 1000) % 10),
                                        4'((SAT_VALUE / 100) % 10),
                                        4'((SAT_VALUE / 10) % 10),
                                        4'(SAT_VALUE % 10)};

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ARMED  = 2'd1,
      S_TIMING = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic        sync1_q, sync1_d;
   logic        sync2_q, sync2_d;
   logic        prev_q, prev_d;
   logic        press_q, press_d;
   logic [15:0] count_q, count_d;
   logic [15:0] best_q, best_d;
   logic        valid_q, valid_d;
   logic        false_start_q, false_start_d;
   logic        overflow_q, overflow_d;
   logic        running_q, running_d;
   logic        entry_q, entry_d;

   // Add one to a 4-digit BCD value, each digit wrapping 9 -> 0 with carry.
   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        carry;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (v[i*4 +: 4] == 4'd9) begin
               r[i*4 +: 4] = 4'd0;
            end else begin
               r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // Key path: two-flop synchronizer, previous-value register and a
   // registered one-cycle press pulse on the synchronized falling edge.
   always_comb begin
      sync1_d = key_n;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
      press_d = prev_q & ~sync2_q;
   end

   // Measurement FSM: next state, count and result flags.
   always_comb begin
      state_d       = state_q;
      count_d       = count_q;
      valid_d       = valid_q;
      false_start_d = false_start_q;
      overflow_d    = overflow_q;
      if (arm) begin
         // A new light sequence always restarts, whatever else is happening.
         state_d       = S_ARMED;
         count_d       = 16'h0000;
         valid_d       = 1'b0;
         false_start_d = 1'b0;
         overflow_d    = 1'b0;
      end else begin
         case (state_q)
            S_ARMED: begin
               // A press wins over a simultaneous lights-out: false start.
               if (press_q) begin
                  state_d       = S_DONE;
                  false_start_d = 1'b1;
                  count_d       = 16'h0000;
               end else if (lights_out) begin
                  state_d = S_TIMING;
                  count_d = 16'h0000;
               end
            end
            S_TIMING: begin
               // A press swallows a coincident tick.
               if (press_q) begin
                  state_d = S_DONE;
                  valid_d = ~overflow_q;
               end else if (tick_ms && (count_q != C_SAT_BCD)) begin
                  count_d = bcd_inc(count_q);
                  if (bcd_inc(count_q) == C_SAT_BCD) begin
                     overflow_d = 1'b1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Status outputs and best-time tracking; best is only considered on the
   // cycle right after DONE is entered.
   always_comb begin
      running_d = (state_d == S_TIMING);
      entry_d   = (state_d == S_DONE) && (state_q != S_DONE);
      best_d    = best_q;
      if (entry_q && valid_q && (count_q < best_q)) begin
         best_d = count_q;
      end
   end

   // State and data registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         sync1_q       <= 1'b1;
         sync2_q       <= 1'b1;
         prev_q        <= 1'b1;
         press_q       <= 1'b0;
         count_q       <= 16'h0000;
         best_q        <= C_SAT_BCD;
         valid_q       <= 1'b0;
         false_start_q <= 1'b0;
         overflow_q    <= 1'b0;
         running_q     <= 1'b0;
         entry_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         sync1_q       <= sync1_d;
         sync2_q       <= sync2_d;
         prev_q        <= prev_d;
         press_q       <= press_d;
         count_q       <= count_d;
         best_q        <= best_d;
         valid_q       <= valid_d;
         false_start_q <= false_start_d;
         overflow_q    <= overflow_d;
         running_q     <= running_d;
         entry_q       <= entry_d;
      end
   end

   assign bcd0        = count_q[3:0];
   assign bcd1        = count_q[7:4];
   assign bcd2        = count_q[11:8];
   assign bcd3        = count_q[15:12];
   assign best0       = best_q[3:0];
   assign best1       = best_q[7:4];
   assign best2       = best_q[11:8];
   assign best3       = best_q[15:12];
   assign valid       = valid_q;
   assign false_start = false_start_q;
   assign overflow    = overflow_q;
   assign running     = running_q;

endmodule
`default_nettype wire

// File: tb/tb_reaction_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_reaction_timer
// Brief    : Self-checking bench for reaction_timer. Directed scenarios plus
//            randomized reaction runs checked against an arithmetic model of
//            the measured time and the running best.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reaction_timer;

   localparam int SAT = 9999;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick_ms = 1'b0;
   logic       arm = 1'b0;
   logic       lights_out = 1'b0;
   logic       key_n = 1'b1;
   logic [3:0] bcd0, bcd1, bcd2, bcd3;
   logic [3:0] best0, best1, best2, best3;
   logic       valid, false_start, overflow, running;

   int vectors = 0;
   int miscompares = 0;
   int m_best = SAT;

   reaction_timer #(.SAT_VALUE(SAT)) dut (
      .clk(clk), .rst(rst), .tick_ms(tick_ms), .arm(arm),
      .lights_out(lights_out), .key_n(key_n),
      .bcd0(bcd0), .bcd1(bcd1), .bcd2(bcd2), .bcd3(bcd3),
      .best0(best0), .best1(best1), .best2(best2), .best3(best3),
      .valid(valid), .false_start(false_start), .overflow(overflow),
      .running(running)
   );

   always #5 clk = ~clk;

   // Watchdog so the bench can never hang.
   initial begin
      #5ms;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // Decimal number to four BCD digits.
   function automatic logic [15:0] to_bcd(input int v);
      return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Apply one cycle of inputs; outputs are sampled 1 ns after the edge.
   task automatic step(input logic t, input logic a, input logic l);
      tick_ms = t; arm = a; lights_out = l;
      @(posedge clk);
      #1;
      tick_ms = 1'b0; arm = 1'b0; lights_out = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0, 1'b0);
   endtask

   task automatic chk_result(input string tag, input int cnt, input logic v,
                             input logic fs, input logic ov, input logic run);
      chk({tag, "_count"}, {16'h0, bcd3, bcd2, bcd1, bcd0}, {16'h0, to_bcd(cnt)});
      chk({tag, "_valid"}, {31'h0, valid}, {31'h0, v});
      chk({tag, "_fs"}, {31'h0, false_start}, {31'h0, fs});
      chk({tag, "_ovf"}, {31'h0, overflow}, {31'h0, ov});
      chk({tag, "_run"}, {31'h0, running}, {31'h0, run});
   endtask

   task automatic chk_best(input string tag, input int b);
      chk({tag, "_best"}, {16'h0, best3, best2, best1, best0}, {16'h0, to_bcd(b)});
   endtask

   // Key goes low; the press pulse is consumed at the fourth edge.
   task automatic press_key();
      key_n = 1'b0;
      idle(4);
   endtask

   task automatic release_key();
      key_n = 1'b1;
      idle(3);
   endtask

   // Full reaction run of n ticks; updates the best-time model.
   task automatic reaction_run(input string tag, input int n);
      int   exp_cnt;
      logic exp_valid;
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      repeat (n) step(1'b1, 1'b0, 1'b0);
      press_key();
      exp_cnt   = (n >= SAT) ? SAT : n;
      exp_valid = (n < SAT);
      chk_result(tag, exp_cnt, exp_valid, 1'b0, !exp_valid, 1'b0);
      if (exp_valid && exp_cnt < m_best) m_best = exp_cnt;
      idle(1);
      chk_best(tag, m_best);
      release_key();
   endtask

   initial begin
      int n;
      idle(3);
      rst = 1'b0;
      chk_result("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_best("reset", SAT);

      // Basic 237 ms run; best lags valid by one edge.
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      chk({"lo_running"}, {31'h0, running}, 32'h1);
      repeat (237) step(1'b1, 1'b0, 1'b0);
      press_key();
      chk_result("r237", 237, 1'b1, 1'b0, 1'b0, 1'b0);
      chk_best("r237_pre", SAT);
      idle(1);
      m_best = 237;
      chk_best("r237_post", m_best);
      release_key();

      // False start, then a stray lights_out is ignored.
      step(1'b0, 1'b1, 1'b0);
      press_key();
      chk_result("fstart", 0, 1'b0, 1'b1, 1'b0, 1'b0);
      release_key();
      step(1'b0, 1'b0, 1'b1);
      repeat (5) step(1'b1, 1'b0, 1'b0);
      chk_result("fstart_lo", 0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk_best("fstart", m_best);

      // Saturation.
      reaction_run("ovf", 10050);

      // Best tracking from a fresh reset.
      rst = 1'b1; idle(1); rst = 1'b0;
      m_best = SAT;
      reaction_run("b310", 310);
      reaction_run("b295", 295);
      reaction_run("b400", 400);

      // Randomized runs against the min model.
      for (int i = 0; i < 4; i++) begin
         n = int'($urandom_range(1, 1500));
         reaction_run("rand", n);
      end

      // Press and lights_out in the same ARMED cycle.
      step(1'b0, 1'b1, 1'b0);
      key_n = 1'b0;
      idle(3);
      step(1'b0, 1'b0, 1'b1);
      chk_result("press_lo", 0, 1'b0, 1'b1, 1'b0, 1'b0);
      release_key();

      // Press coinciding with a tick: 99, not 100.
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      repeat (96) step(1'b1, 1'b0, 1'b0);
      key_n = 1'b0;
      repeat (4) step(1'b1, 1'b0, 1'b0);
      chk_result("press_tick", 99, 1'b1, 1'b0, 1'b0, 1'b0);
      if (99 < m_best) m_best = 99;
      idle(1);
      chk_best("press_tick", m_best);
      release_key();

      // Arm during TIMING restarts into ARMED; ticks there are ignored.
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      repeat (50) step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      chk_result("rearm", 0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      chk_result("rearm_tick", 0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      repeat (5) step(1'b1, 1'b0, 1'b0);
      press_key();
      chk_result("rearm_run", 5, 1'b1, 1'b0, 1'b0, 1'b0);
      if (5 < m_best) m_best = 5;

      // Held key produces no second press.
      idle(1000);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      repeat (20) step(1'b1, 1'b0, 1'b0);
      idle(10);
      chk_result("held", 20, 1'b0, 1'b0, 1'b0, 1'b1);
      release_key();
      press_key();
      chk_result("repress", 20, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(1);
      chk_best("repress", m_best);
      release_key();

      // Reset mid-TIMING.
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      repeat (30) step(1'b1, 1'b0, 1'b0);
      rst = 1'b1;
      idle(1);
      chk_result("midrst", 0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_best("midrst", SAT);
      rst = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/reaction_timer.md
# reaction_timer

Measures the driver's reaction time in milliseconds for the starting-lights game. Sits directly downstream of the starting-lights FSM and its random delay. It arms when a light sequence begins, starts counting on the lights-out event, and stops on the player's key press. It produces a 4-digit BCD result, a false-start flag, and a best-time register, which feed the `hex_to_7seg` display stage.

## Interface
Parameters:
- `SAT_VALUE`, default 9999: BCD saturation value of the counter. It is also the reset value of the best time.

Ports:
- `clk`, input, 1: system clock (CLOCK_50 domain).
- `rst`, input, 1: synchronous, active-high reset.
- `tick_ms`, input, 1: one-cycle enable pulse, one per millisecond.
- `arm`, input, 1: one-cycle pulse when the light sequence starts (the FSM's trigger accept).
- `lights_out`, input, 1: one-cycle pulse when all lights go out (the delay timeout).
- `key_n`, input, 1: raw, asynchronous, active-low player button.
- `bcd0`..`bcd3`, output, 4 each: current/last reaction time in BCD; `bcd0` is the ms units digit.
- `best0`..`best3`, output, 4 each: best valid time in BCD.
- `valid`, output, 1: the result is a completed, legal measurement.
- `false_start`, output, 1: the key was pressed before lights out.
- `overflow`, output, 1: the count saturated at `SAT_VALUE`.
- `running`, output, 1: high while in TIMING.

## Operation
Key path:
- `key_n` passes through a 2-flop synchronizer, then a previous-value register.
- `press` is a one-cycle internal pulse on a synchronized 1→0 transition.
- Holding the key produces a single press.

States: IDLE, ARMED, TIMING, DONE.
- IDLE: waits for `arm`. On `arm`: clear the count to 0, clear `valid`, `false_start` and `overflow`, then go to ARMED.
- ARMED:
  - `press` sets `false_start`, zeroes the count, and goes to DONE.
  - Otherwise `lights_out` goes to TIMING with the count at 0.
  - `press` and `lights_out` in the same cycle count as a false start.
- TIMING:
  - Each `tick_ms` increments the BCD count. Digits wrap 9→0 with carry into the next digit.
  - At `SAT_VALUE` the count holds and `overflow` is set.
  - `press` goes to DONE and sets `valid`, unless `overflow` is set.
  - If `press` and `tick_ms` coincide, the tick is not counted.
- DONE:
  - Holds the result and flags.
  - If `valid` and count < best, best ← count. This update happens in the DONE entry cycle only.
  - `arm` goes to ARMED, as in IDLE.
- `arm` in ARMED or TIMING restarts: clear the count and flags, stay in or return to ARMED. `arm` has priority over `press` and `lights_out`.
- A `lights_out` or `press` pulse in IDLE or DONE is ignored.
- Comparison is on the 16-bit BCD value. Digit-wise BCD ordering equals numeric ordering, so an unsigned compare is legal.

## Timing
Reset:
- State IDLE.
- `bcd0..3` = 0.
- `best0..3` = the digits of `SAT_VALUE` (9,9,9,9).
- `valid`, `false_start`, `overflow`, `running` = 0.
- Synchronizer flops = 1 (key released).

Key latency:
- `key_n` is low at clock edge k.
- `press` is high in the cycle after edge k+2, for exactly one cycle.
- The state change is visible after edge k+3.

Event latency:
- `arm`, `lights_out`, `tick_ms` and `press` take effect on the next clock edge.
- Outputs are registered; no combinational input→output paths.
- `running` is high from the edge that enters TIMING to the edge that leaves it.
- The count is updated on the same edge as the `tick_ms` it consumes.
- The best time updates one edge after `valid` rises.
- Reset mid-operation returns everything to the reset values above, including best. The best time is not preserved.

## Test plan
- Reset, then `arm`, `lights_out`, 237 `tick_ms` pulses, then drive `key_n` low → bcd3..0 = 0,2,3,7; `valid`=1; best = 0237 one cycle later.
- `arm`, then `key_n` low before `lights_out` → `false_start`=1, `valid`=0, count 0000, best unchanged; a later `lights_out` is ignored.
- `lights_out`, 10050 ticks, then press → count holds at 9999, `overflow`=1, `valid`=0, best unchanged.
- Two runs, 0310 then 0295, then a third of 0400 → best = 0310, then 0295, and stays 0295 after the 0400 run.
- Same-cycle events:
  - `press` and `lights_out` together in ARMED → false start.
  - `press` and `tick_ms` together in TIMING after 99 ticks → result 0099, not 0100.
  - `arm` during TIMING → count clears, ARMED.
- Key held low for 1000 cycles after a valid stop, then `arm` → no second press; the next press is detected only after a release and re-press.
- Reset asserted mid-TIMING → all outputs at their reset values on the next edge.
